cpuif_pixel_bridge: RTL and testbench
=====================================

// Module: cpuif_pixel_bridge
// PURPOSE
//  Sits directly downstream of the GPMC synchronous front-end, in the clk domain. Consumes its
//  single-cycle req strobes and returns rd_ack/rd_data. Decodes each request into one of 2 windows:
//  - a pixel-word FIFO that drains to the LED frame pipeline;
//  - a pass-through port to the register block, guarded by a response timeout.
// PARAMETERS
//  ADDR_WIDTH    17       byte address width (GPMC word address plus appended 0)
//  DATA_WIDTH    16       data word width
//  FIFO_DEPTH    256      pixel FIFO entries, power of 2
//  FIFO_BASE     5'h1F    addr[16:12] value selecting the FIFO window
//  TIMEOUT       64       clk cycles to wait for a register-block ack
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high reset
//  req          in   1           request strobe, 1 cycle
//  req_is_wr    in   1           1=write, 0=read; valid with req
//  addr         in   ADDR_WIDTH  byte address; valid with req
//  wr_data      in   DATA_WIDTH  write data; valid with req
//  rd_ack       out  1           read response strobe
//  rd_data      out  DATA_WIDTH  read data; valid with rd_ack
//  reg_req      out  1           forwarded request strobe
//  reg_is_wr    out  1           forwarded direction
//  reg_addr     out  ADDR_WIDTH  forwarded address
//  reg_wr_data  out  DATA_WIDTH  forwarded write data
//  reg_ack      in   1           register block ack, read or write
//  reg_rd_data  in   DATA_WIDTH  register block read data; valid with reg_ack
//  pix_valid    out  1           FIFO head word valid
//  pix_data     out  DATA_WIDTH  FIFO head word
//  pix_ready    in   1           consumer pops the head when pix_valid & pix_ready
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; all counters 0; FSM in IDLE.
//  Decode: the FIFO window is selected when addr[16:12]==FIFO_BASE; all other addresses are forwarded.
//  FIFO window. Offsets are addr[3:0]; every access is acked or completed 1 cycle after req.
//   0x0 W  push wr_data. If full: drop the word and increment ovf_cnt, saturating at 16'hFFFF.
//   0x2 R  {ovf_cnt!=0, level}, zero-extended; level width = $clog2(FIFO_DEPTH)+1.
//   0x4 W  wr_data[0]=1 flushes the FIFO; the flush wins over a same-cycle pop.
//   0x6 R  ovf_cnt.   0x6 W  clears ovf_cnt.
//   0x8 R  {drop_cnt[7:0], tmo_cnt[7:0]}.   0x8 W  clears both counters.
//   Other offsets: R returns 16'h0000; W is ignored.
//  FIFO behaviour:
//   - First-word-fall-through.
//   - Push lands on the clk after req; pix_valid rises the clk after the push.
//   - Simultaneous push and pop: level unchanged, both take effect.
//   - Pop when empty: no effect.
//   - Wrap-around: read and write pointers wrap mod FIFO_DEPTH.
//  Forwarding FSM:
//   IDLE: on a non-FIFO req, capture the request and go to ISSUE.
//   ISSUE: assert reg_req with the captured fields for exactly 1 cycle, then go to WAIT.
//   WAIT: on reg_ack, go to IDLE; for a read, rd_ack=1 and rd_data=reg_rd_data in the next cycle.
//         If TIMEOUT cycles pass without reg_ack: increment tmo_cnt (saturating); for a read,
//         pulse rd_ack with rd_data=16'hDEAD; go to IDLE.
//   - A reg_ack while in IDLE or ISSUE is ignored.
//   - A reg_ack in the same cycle as timeout expiry is treated as an ack; tmo_cnt is unchanged.
//  Busy rule: a req arriving while the FSM is not in IDLE is dropped (no ack; drop_cnt++, saturating).
//   This applies to both windows, so responses stay in order.
//  Response timing: rd_ack is high for exactly 1 cycle per accepted read; rd_data is 0 when
//   rd_ack is 0.
//  Reset asserted mid-operation aborts an outstanding forward with no ack and empties the FIFO.
// TESTING
//  1. Write 0x1F000 = 0x1234, 0x5678, pix_ready=0 -> pix_valid by req+2; pix_data=0x1234;
//     read 0x1F002 returns 0x0002.
//  2. Fill FIFO with 256 words, then 3 more -> read 0x1F006=3 and 0x1F002=0x8100;
//     write 0x1F006 -> reads 0.
//  3. Read 0x00010; reg_ack 5 cycles after reg_req with reg_rd_data=0xBEEF
//     -> a single rd_ack with rd_data=0xBEEF.
//  4. Read 0x00020 with no reg_ack -> rd_ack at timeout carrying 0xDEAD; 0x1F008 low byte=1.
//  5. Second req issued during WAIT -> it is dropped; 0x1F008 high byte=1; first response intact.
//  6. Push and pop in the same cycle with level=4 -> level stays 4; flush -> pix_valid=0 next cycle.

Source files
------------

// File: rtl/cpuif_pixel_bridge.sv
// CPU-interface bridge: decodes GPMC front-end requests into a pixel-word FIFO window
// and a timeout-guarded pass-through to the register block.
module cpuif_pixel_bridge #(
  parameter int         ADDR_WIDTH = 17,
  parameter int         DATA_WIDTH = 16,
  parameter int         FIFO_DEPTH = 256,
  parameter logic [4:0] FIFO_BASE  = 5'h1F,
  parameter int         TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_is_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  reg_req,
  output logic                  reg_is_wr,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic                  reg_ack,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_ready,
  output logic [1:0]            dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         wait_cnt;
  logic                  cap_is_wr;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic [15:0]           ovf_cnt;
  logic [7:0]            drop_cnt, tmo_cnt;

  logic                  fifo_win, accept, fifo_wr, fifo_rd;
  logic [3:0]            offset;
  logic                  full, push, push_ok, flush, pop;
  logic                  fwd_done, fwd_tmo;
  logic [DATA_WIDTH-1:0] csr_rdata;

  // Handshakes: req/reg_req/rd_ack are single-cycle strobes with no back-pressure; a req is
  // accepted only while the FSM is IDLE, otherwise it is dropped and counted. The pixel port
  // pops the head on any cycle where pix_valid & pix_ready.
  assign fifo_win = (addr[ADDR_WIDTH-1 -: 5] == FIFO_BASE);
  assign accept   = req && (state == S_IDLE);
  assign offset   = addr[3:0];
  assign fifo_wr  = accept && fifo_win && req_is_wr;
  assign fifo_rd  = accept && fifo_win && !req_is_wr;
  assign full     = (level == LW'(FIFO_DEPTH));
  assign push     = fifo_wr && (offset == 4'h0);
  assign push_ok  = push && !full;
  assign flush    = fifo_wr && (offset == 4'h4) && wr_data[0];
  assign pix_valid = (level != '0);
  assign pop      = pix_valid && pix_ready;
  assign pix_data = pix_valid ? mem[rd_ptr] : '0;

  assign reg_is_wr   = cap_is_wr;
  assign reg_addr    = cap_addr;
  assign reg_wr_data = cap_data;
  assign dbg_state   = state;

  // Status word: overflow flag in the top bit, level zero-extended in the low bits.
  always_comb begin
    csr_rdata = '0;
    case (offset)
      4'h2: begin
        csr_rdata[DATA_WIDTH-1] = (ovf_cnt != '0);
        csr_rdata[LW-1:0]       = level;
      end
      4'h6:    csr_rdata = DATA_WIDTH'(ovf_cnt);
      4'h8:    csr_rdata = DATA_WIDTH'({drop_cnt, tmo_cnt});
      default: csr_rdata = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    reg_req   = 1'b0;
    fwd_done  = 1'b0;
    fwd_tmo   = 1'b0;
    case (state)
      S_IDLE:  if (req && !fifo_win) state_nxt = S_ISSUE;
      S_ISSUE: begin
        reg_req   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the expiry cycle still counts as a normal completion.
        if (reg_ack) begin
          fwd_done  = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          fwd_tmo   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      cap_is_wr <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
      if (accept && !fifo_win) begin
        cap_is_wr <= req_is_wr;
        cap_addr  <= addr;
        cap_data  <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack   <= 1'b0;
      rd_data  <= '0;
      ovf_cnt  <= '0;
      drop_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
      if (fifo_rd) begin
        rd_ack  <= 1'b1;
        rd_data <= csr_rdata;
      end else if (!cap_is_wr && (fwd_done || fwd_tmo)) begin
        rd_ack  <= 1'b1;
        rd_data <= fwd_done ? reg_rd_data : DATA_WIDTH'(16'hDEAD);
      end

      if (push && full && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
      else if (fifo_wr && (offset == 4'h6))       ovf_cnt <= '0;

      if (fwd_tmo && (tmo_cnt != 8'hFF))    tmo_cnt <= tmo_cnt + 8'd1;
      else if (fifo_wr && (offset == 4'h8)) tmo_cnt <= '0;

      if (req && (state != S_IDLE) && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      else if (fifo_wr && (offset == 4'h8))                 drop_cnt <= '0;
    end
  end

  // Flush resets both pointers; it cannot coincide with a push and overrides any pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_cpuif_pixel_bridge.sv
// Bench for cpuif_pixel_bridge: pixel FIFO modelled as a word queue, counters as integers,
// register block emulated by a responder inside fwd_txn.
module tb_cpuif_pixel_bridge;
  localparam int AW    = 17;
  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int TMO   = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, req_is_wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          reg_req, reg_is_wr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wr_data;
  logic          reg_ack;
  logic [DW-1:0] reg_rd_data;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  int ovf_m = 0, drop_m = 0, tmo_m = 0;

  cpuif_pixel_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_BASE(5'h1F), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_is_wr(req_is_wr), .addr(addr),
    .wr_data(wr_data), .rd_ack(rd_ack), .rd_data(rd_data), .reg_req(reg_req),
    .reg_is_wr(reg_is_wr), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_ack(reg_ack), .reg_rd_data(reg_rd_data), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model helpers ----------------
  function automatic logic [AW-1:0] fifo_addr(input logic [3:0] off);
    return {5'h1F, 8'h00, off};
  endfunction

  function automatic logic [DW-1:0] status_exp();
    logic [DW-1:0] v;
    v = DW'(exp_q.size());
    if (ovf_m != 0) v[15] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] cnt_exp();
    logic [7:0] dd, tt;
    dd = (drop_m > 255) ? 8'hFF : 8'(drop_m);
    tt = (tmo_m > 255) ? 8'hFF : 8'(tmo_m);
    return {dd, tt};
  endfunction

  task automatic model_push(input logic [DW-1:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else if (ovf_m < 65535) ovf_m++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fifo_access(input logic wr, input logic [3:0] off, input logic [DW-1:0] d,
                             output logic ack, output logic [DW-1:0] rdat);
    req = 1'b1; req_is_wr = wr; addr = fifo_addr(off); wr_data = d;
    tick();
    req = 1'b0; req_is_wr = 1'b0; addr = '0; wr_data = '0;
    ack = rd_ack;
    rdat = rd_data;
  endtask

  task automatic drain_all(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      checks++;
      if (pix_valid !== 1'b1) begin
        failures++; $display("FAIL %s_valid: got %b expected 1", name, pix_valid);
      end
      checks++;
      if (pix_data !== exp_q[0]) begin
        failures++; $display("FAIL %s_data: got %h expected %h", name, pix_data, exp_q[0]);
      end
      if (pix_ready) void'(exp_q.pop_front());
      tick();
      guard++;
    end
    pix_ready = 1'b0;
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++; $display("FAIL %s_empty: got pix_valid=%b expected 0", name, pix_valid);
    end
  endtask

  // Forwarded transaction with an emulated register block. ack_d: -1 never acks, 0 acks in
  // the reg_req cycle, k>0 acks k cycles after reg_req. drop_at >= 0 injects a FIFO push
  // that many cycles after reg_req, which must be discarded.
  task automatic fwd_txn(input string name, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int ack_d, input int drop_at);
    logic [DW-1:0] rsp, got, exp_d;
    int n_ack, ack_cyc, nz_idle, exp_cyc;
    bit timed_out;
    rsp = DW'($urandom);
    got = '0; n_ack = 0; ack_cyc = -1; nz_idle = 0;
    req = 1'b1; req_is_wr = wr; addr = a; wr_data = d;
    tick();
    req = 1'b0; req_is_wr = 1'b0; addr = '0; wr_data = '0;
    checks++;
    if (reg_req !== 1'b1) begin
      failures++; $display("FAIL %s_reg_req: got %b expected 1", name, reg_req);
    end
    checks++;
    if ({reg_is_wr, reg_addr, reg_wr_data} !== {wr, a, d}) begin
      failures++;
      $display("FAIL %s_fields: got wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h",
               name, reg_is_wr, reg_addr, reg_wr_data, wr, a, d);
    end
    if (ack_d == 0) begin reg_ack = 1'b1; reg_rd_data = rsp; end
    if (drop_at == 0) begin
      req = 1'b1; req_is_wr = 1'b1; addr = fifo_addr(4'h0); wr_data = 16'hAAAA; drop_m++;
    end
    for (int c = 1; c <= TMO + 4; c++) begin
      tick();
      reg_ack = 1'b0; reg_rd_data = '0;
      req = 1'b0; req_is_wr = 1'b0; addr = '0; wr_data = '0;
      if (c == 1) begin
        checks++;
        if (reg_req !== 1'b0) begin
          failures++; $display("FAIL %s_reg_req_width: got %b expected 0", name, reg_req);
        end
      end
      if (rd_ack === 1'b1) begin
        n_ack++; ack_cyc = c; got = rd_data;
      end else if (rd_data !== '0) begin
        nz_idle++;
      end
      if (c == ack_d) begin reg_ack = 1'b1; reg_rd_data = rsp; end
      if (c == drop_at) begin
        req = 1'b1; req_is_wr = 1'b1; addr = fifo_addr(4'h0); wr_data = 16'hAAAA; drop_m++;
      end
    end
    timed_out = !(ack_d >= 1 && ack_d <= TMO);
    if (timed_out) tmo_m++;
    exp_cyc = timed_out ? TMO + 1 : ack_d + 1;
    exp_d = timed_out ? 16'hDEAD : rsp;
    if (wr) begin
      checks++;
      if (n_ack !== 0) begin
        failures++; $display("FAIL %s_wr_no_ack: got %0d acks expected 0", name, n_ack);
      end
    end else begin
      checks++;
      if (n_ack !== 1) begin
        failures++; $display("FAIL %s_ack_count: got %0d expected 1", name, n_ack);
      end
      checks++;
      if (ack_cyc !== exp_cyc) begin
        failures++; $display("FAIL %s_ack_cycle: got %0d expected %0d", name, ack_cyc, exp_cyc);
      end
      checks++;
      if (got !== exp_d) begin
        failures++; $display("FAIL %s_rd_data: got %h expected %h", name, got, exp_d);
      end
    end
    checks++;
    if (nz_idle !== 0) begin
      failures++; $display("FAIL %s_rd_data_idle: got %0d nonzero cycles expected 0", name, nz_idle);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic ack; logic [DW-1:0] r;
    reset = 1'b1; req = 1'b0; req_is_wr = 1'b0; addr = '0; wr_data = '0;
    reg_ack = 1'b0; reg_rd_data = '0; pix_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rd_ack, reg_req, reg_is_wr, pix_valid} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes: got %b expected 0000", {rd_ack, reg_req, reg_is_wr, pix_valid});
    end
    checks++;
    if ({rd_data, pix_data, reg_wr_data} !== '0) begin
      failures++; $display("FAIL reset_data: got %h %h %h expected 0", rd_data, pix_data, reg_wr_data);
    end
    checks++;
    if (reg_addr !== '0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_fsm: got addr=%h state=%0d expected 0", reg_addr, dbg_state);
    end
    reset = 1'b0;
    tick();
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (ack !== 1'b1 || r !== 16'h0000) begin
      failures++; $display("FAIL reset_status: got ack=%b data=%h expected 1/0000", ack, r);
    end
    fifo_access(1'b0, 4'h8, '0, ack, r);
    checks++;
    if (ack !== 1'b1 || r !== 16'h0000) begin
      failures++; $display("FAIL reset_counters: got ack=%b data=%h expected 1/0000", ack, r);
    end
  endtask

  task automatic test_push_basic();
    logic ack; logic [DW-1:0] r;
    pix_ready = 1'b0;
    fifo_access(1'b1, 4'h0, 16'h1234, ack, r); model_push(16'h1234);
    fifo_access(1'b1, 4'h0, 16'h5678, ack, r); model_push(16'h5678);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h1234) begin
      failures++; $display("FAIL push_head: got valid=%b data=%h expected 1/1234", pix_valid, pix_data);
    end
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (ack !== 1'b1 || r !== status_exp()) begin
      failures++; $display("FAIL push_status: got ack=%b data=%h expected 1/%h", ack, r, status_exp());
    end
  endtask

  task automatic test_overflow();
    logic ack; logic [DW-1:0] r, d;
    drain_all("ovf_predrain");
    for (int i = 0; i < DEPTH + 3; i++) begin
      d = DW'($urandom);
      fifo_access(1'b1, 4'h0, d, ack, r);
      model_push(d);
    end
    fifo_access(1'b0, 4'h6, '0, ack, r);
    checks++;
    if (r !== DW'(ovf_m) || ovf_m != 3) begin
      failures++; $display("FAIL ovf_count: got %h expected %h", r, DW'(ovf_m));
    end
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (r !== status_exp()) begin
      failures++; $display("FAIL ovf_status_full: got %h expected %h", r, status_exp());
    end
    fifo_access(1'b1, 4'h6, '0, ack, r); ovf_m = 0;
    fifo_access(1'b0, 4'h6, '0, ack, r);
    checks++;
    if (r !== 16'h0000) begin
      failures++; $display("FAIL ovf_clear: got %h expected 0000", r);
    end
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (r !== status_exp()) begin
      failures++; $display("FAIL ovf_status_clear: got %h expected %h", r, status_exp());
    end
    drain_all("ovf_drain");
  endtask

  task automatic test_fwd_read();
    fwd_txn("fwd_read", 1'b0, 17'h00010, '0, 5, -1);
  endtask

  task automatic test_fwd_timeout();
    logic ack; logic [DW-1:0] r;
    fifo_access(1'b1, 4'h8, '0, ack, r); drop_m = 0; tmo_m = 0;
    fwd_txn("fwd_tmo", 1'b0, 17'h00020, '0, -1, -1);
    fifo_access(1'b0, 4'h8, '0, ack, r);
    checks++;
    if (r !== cnt_exp()) begin
      failures++; $display("FAIL tmo_counter: got %h expected %h", r, cnt_exp());
    end
  endtask

  task automatic test_timeout_edges();
    logic ack; logic [DW-1:0] r;
    fwd_txn("ack_at_limit", 1'b0, AW'($urandom_range(0, 17'h1EFFF)), '0, TMO, -1);
    fwd_txn("ack_after_limit", 1'b0, AW'($urandom_range(0, 17'h1EFFF)), '0, TMO + 1, -1);
    fwd_txn("ack_in_issue", 1'b0, AW'($urandom_range(0, 17'h1EFFF)), '0, 0, -1);
    fwd_txn("fwd_write_ack", 1'b1, AW'($urandom_range(0, 17'h1EFFF)), DW'($urandom), 3, -1);
    fwd_txn("fwd_write_tmo", 1'b1, AW'($urandom_range(0, 17'h1EFFF)), DW'($urandom), -1, -1);
    fwd_txn("fwd_read_rand", 1'b0, AW'($urandom_range(0, 17'h1EFFF)), '0, $urandom_range(1, TMO), -1);
    fifo_access(1'b0, 4'h8, '0, ack, r);
    checks++;
    if (r !== cnt_exp()) begin
      failures++; $display("FAIL edge_counters: got %h expected %h", r, cnt_exp());
    end
  endtask

  task automatic test_busy_drop();
    logic ack; logic [DW-1:0] r;
    fifo_access(1'b1, 4'h8, '0, ack, r); drop_m = 0; tmo_m = 0;
    fwd_txn("busy_wait", 1'b0, 17'h00030, '0, 10, 4);
    fifo_access(1'b0, 4'h8, '0, ack, r);
    checks++;
    if (r !== cnt_exp()) begin
      failures++; $display("FAIL busy_counters: got %h expected %h", r, cnt_exp());
    end
    fwd_txn("busy_issue", 1'b0, 17'h00032, '0, 7, 0);
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (r !== status_exp()) begin
      failures++; $display("FAIL busy_level: got %h expected %h", r, status_exp());
    end
    fifo_access(1'b0, 4'h8, '0, ack, r);
    checks++;
    if (r !== cnt_exp()) begin
      failures++; $display("FAIL busy_counters2: got %h expected %h", r, cnt_exp());
    end
    fifo_access(1'b1, 4'h8, '0, ack, r); drop_m = 0; tmo_m = 0;
    fifo_access(1'b0, 4'h8, '0, ack, r);
    checks++;
    if (r !== 16'h0000) begin
      failures++; $display("FAIL counters_clear: got %h expected 0000", r);
    end
  endtask

  task automatic test_push_pop_flush();
    logic ack; logic [DW-1:0] r, d;
    drain_all("ppf_predrain");
    for (int i = 0; i < 4; i++) begin
      d = DW'($urandom);
      fifo_access(1'b1, 4'h0, d, ack, r);
      model_push(d);
    end
    d = DW'($urandom);
    pix_ready = 1'b1;
    fifo_access(1'b1, 4'h0, d, ack, r);
    pix_ready = 1'b0;
    void'(exp_q.pop_front());
    model_push(d);
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (r !== status_exp() || exp_q.size() != 4) begin
      failures++; $display("FAIL pushpop_level: got %h expected %h", r, status_exp());
    end
    checks++;
    if (pix_data !== exp_q[0]) begin
      failures++; $display("FAIL pushpop_head: got %h expected %h", pix_data, exp_q[0]);
    end
    fifo_access(1'b1, 4'h4, 16'hFFFE, ack, r);
    fifo_access(1'b1, 4'h2, 16'hFFFF, ack, r);
    fifo_access(1'b1, 4'hA, 16'hFFFF, ack, r);
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (r !== status_exp()) begin
      failures++; $display("FAIL noflush_level: got %h expected %h", r, status_exp());
    end
    pix_ready = 1'b1;
    fifo_access(1'b1, 4'h4, 16'h0001, ack, r);
    pix_ready = 1'b0;
    exp_q.delete();
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++; $display("FAIL flush_valid: got %b expected 0", pix_valid);
    end
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (r !== status_exp()) begin
      failures++; $display("FAIL flush_level: got %h expected %h", r, status_exp());
    end
  endtask

  task automatic test_random();
    logic [3:0] other_offs [12] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h7,
                                    4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [3:0] off;
      logic [DW-1:0] d, exp_rd;
      logic is_rd, pop_exp, full_b;
      op = $urandom_range(0, 9);
      d = DW'($urandom);
      is_rd = 1'b0; exp_rd = '0; off = 4'h0;
      pix_ready = 1'($urandom_range(0, 1));
      checks++;
      if (pix_valid !== (exp_q.size() != 0)) begin
        failures++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, pix_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (pix_data !== exp_q[0]) begin
          failures++; $display("FAIL rand_head[%0d]: got %h expected %h", i, pix_data, exp_q[0]);
        end
      end
      pop_exp = (exp_q.size() != 0) && pix_ready;
      full_b = (exp_q.size() >= DEPTH);
      if (op <= 4) begin
        req = 1'b1; req_is_wr = 1'b1; addr = fifo_addr(4'h0); wr_data = d;
      end else if (op <= 8) begin
        if (op <= 6)      begin off = 4'h2; exp_rd = status_exp(); end
        else if (op == 7) begin off = 4'h6; exp_rd = DW'(ovf_m); end
        else              begin off = other_offs[$urandom_range(0, 11)]; exp_rd = '0; end
        is_rd = 1'b1;
        req = 1'b1; req_is_wr = 1'b0; addr = fifo_addr(off); wr_data = d;
      end
      tick();
      req = 1'b0; req_is_wr = 1'b0; addr = '0; wr_data = '0;
      if (pop_exp) void'(exp_q.pop_front());
      if (op <= 4) begin
        if (!full_b) exp_q.push_back(d);
        else if (ovf_m < 65535) ovf_m++;
      end
      checks++;
      if (rd_ack !== is_rd || rd_data !== exp_rd) begin
        failures++;
        $display("FAIL rand_resp[%0d] off=%h: got ack=%b data=%h expected ack=%b data=%h",
                 i, off, rd_ack, rd_data, is_rd, exp_rd);
      end
    end
    pix_ready = 1'b0;
    drain_all("rand_drain");
  endtask

  task automatic test_reset_abort();
    int n_ack, n_req;
    logic ack; logic [DW-1:0] r;
    for (int i = 0; i < 3; i++) begin
      fifo_access(1'b1, 4'h0, DW'($urandom), ack, r);
    end
    req = 1'b1; req_is_wr = 1'b0; addr = 17'h00040;
    tick();
    req = 1'b0; addr = '0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    exp_q.delete(); ovf_m = 0; drop_m = 0; tmo_m = 0;
    checks++;
    if (pix_valid !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL abort_state: got valid=%b state=%0d expected 0/0", pix_valid, dbg_state);
    end
    n_ack = 0; n_req = 0;
    for (int c = 0; c < TMO + 10; c++) begin
      reg_ack = (c == 5);
      reg_rd_data = 16'h5A5A;
      tick();
      if (rd_ack === 1'b1) n_ack++;
      if (reg_req === 1'b1) n_req++;
    end
    reg_ack = 1'b0; reg_rd_data = '0;
    checks++;
    if (n_ack !== 0 || n_req !== 0) begin
      failures++; $display("FAIL abort_quiet: got %0d rd_ack %0d reg_req expected 0/0", n_ack, n_req);
    end
    fifo_access(1'b0, 4'h2, '0, ack, r);
    checks++;
    if (ack !== 1'b1 || r !== status_exp()) begin
      failures++; $display("FAIL abort_status: got ack=%b data=%h expected 1/%h", ack, r, status_exp());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_push_basic();
    test_overflow();
    test_fwd_read();
    test_fwd_timeout();
    test_timeout_edges();
    test_busy_drop();
    test_push_pop_flush();
    test_random();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
